// File: rtl/ras_decoded_branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// ras_decoded_branch_resolver_pkg
// Fetch-unit types shared by the decode-stage branch resolver and its
// return-address stack.
//   RAS_DEPTH        : default number of return-address-stack entries
//   RasPtrPath       : RAS top-of-stack pointer
//   RasCountPath     : RAS occupancy (0..RAS_DEPTH, one bit wider than ptr)
//   RasCheckpoint    : {top, count} snapshot stored with each instruction
//   BranchTargetType : which target a decode lane resolves to
// No ports (package).
// -----------------------------------------------------------------------------
package ras_decoded_branch_resolver_pkg;

  localparam int RAS_DEPTH     = 8;
  localparam int RAS_PTR_WIDTH = $clog2(RAS_DEPTH);

  typedef logic [RAS_PTR_WIDTH-1:0] RasPtrPath;
  typedef logic [RAS_PTR_WIDTH:0]   RasCountPath;

  typedef struct packed {
    RasPtrPath   top;
    RasCountPath count;
  } RasCheckpoint;

  typedef enum logic [1:0] {
    BTT_NONE    = 2'd0,  // lane does not redirect
    BTT_NEXT_PC = 2'd1,  // pc + INSN_BYTES (false taken / serialized)
    BTT_PC_REL  = 2'd2,  // pc + disp (conditional branch / JAL)
    BTT_RETURN  = 2'd3   // return address from the RAS
  } BranchTargetType;

endpackage

// File: rtl/ras_decoded_branch_resolver_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack used by ras_decoded_branch_resolver. Only
// present when RSD_RAS_RETURN_PREDICT_EN is defined.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   update               : commit the lanes selected by apply this cycle
//   apply                : lanes (a prefix of the group) whose ops commit
//   push, pop            : per-lane call / return operations (already valid-gated)
//   pushAddr             : per-lane return address written on a push
//   recover, recoverTop,
//   recoverCount         : backend restore of pointer and occupancy
//   ckptTop, ckptCount   : per-lane state before that lane's operation
//   topAddr              : per-lane RAS[top], forwarding pushes of lower lanes
// -----------------------------------------------------------------------------
`ifdef RSD_RAS_RETURN_PREDICT_EN
module ras_stack #(
  parameter int DECODE_WIDTH = 2,
  parameter int RAS_DEPTH    = 8,
  parameter int PC_WIDTH     = 32,
  parameter int PTR_WIDTH    = $clog2(RAS_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   update,
  input  logic [DECODE_WIDTH-1:0]                apply,
  input  logic [DECODE_WIDTH-1:0]                push,
  input  logic [DECODE_WIDTH-1:0]                pop,
  input  logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0]  pushAddr,
  input  logic                                   recover,
  input  logic [PTR_WIDTH-1:0]                   recoverTop,
  input  logic [PTR_WIDTH:0]                     recoverCount,
  output logic [DECODE_WIDTH-1:0][PTR_WIDTH-1:0] ckptTop,
  output logic [DECODE_WIDTH-1:0][PTR_WIDTH:0]   ckptCount,
  output logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0]  topAddr
);
  import ras_decoded_branch_resolver_pkg::*;

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(RAS_DEPTH);

  logic [PC_WIDTH-1:0]                   entries [RAS_DEPTH];
  logic [PTR_WIDTH-1:0]                  topReg;
  logic [PTR_WIDTH:0]                    countReg;
  logic [DECODE_WIDTH-1:0][PTR_WIDTH-1:0] wrIdx;
  logic [DECODE_WIDTH-1:0][PTR_WIDTH-1:0] postTop;
  logic [DECODE_WIDTH-1:0][PTR_WIDTH:0]   postCount;
  logic [PTR_WIDTH-1:0]                  nextTop;
  logic [PTR_WIDTH:0]                    nextCount;

  // Walk the lanes in order: checkpoint, pop (if non-empty), then push.
  always_comb begin
    logic [PTR_WIDTH-1:0] t;
    logic [PTR_WIDTH:0]   c;
    t = topReg;
    c = countReg;
    ckptTop   = '0;
    ckptCount = '0;
    wrIdx     = '0;
    postTop   = '0;
    postCount = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      ckptTop[i]   = t;
      ckptCount[i] = c;
      if (pop[i] && (c != '0)) begin
        t = t - 1'b1;
        c = c - 1'b1;
      end else begin
        t = t;
      end
      // Slot a push from this lane lands in; overflow simply wraps onto the oldest.
      wrIdx[i] = t + 1'b1;
      if (push[i]) begin
        t = t + 1'b1;
        c = (c == FULL_COUNT) ? c : c + 1'b1;
      end else begin
        t = t;
      end
      postTop[i]   = t;
      postCount[i] = c;
    end
  end

  // Return address seen by each lane; the latest lower-lane push to that slot wins.
  always_comb begin
    topAddr = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      topAddr[i] = entries[ckptTop[i]];
      for (int j = 0; j < DECODE_WIDTH; j++) begin
        topAddr[i] = ((j < i) && push[j] && (wrIdx[j] == ckptTop[i])) ? pushAddr[j] : topAddr[i];
      end
    end
  end

  // State after the last committed lane (apply is a prefix mask).
  always_comb begin
    nextTop   = topReg;
    nextCount = countReg;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (apply[i]) begin
        nextTop   = postTop[i];
        nextCount = postCount[i];
      end else begin
        nextTop   = nextTop;
      end
    end
  end

  // Stack state: reset beats recover, recover beats decode updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      topReg   <= '0;
      countReg <= '0;
      for (int k = 0; k < RAS_DEPTH; k++) begin
        entries[k] <= '0;
      end
    end else if (recover) begin
      topReg   <= recoverTop;
      countReg <= recoverCount;
    end else if (update) begin
      topReg   <= nextTop;
      countReg <= nextCount;
      for (int j = 0; j < DECODE_WIDTH; j++) begin
        if (push[j] && apply[j]) begin
          entries[wrIdx[j]] <= pushAddr[j];
        end
      end
    end
  end

endmodule
`endif

// File: rtl/ras_decoded_branch_resolver.sv
// -----------------------------------------------------------------------------
// ras_decoded_branch_resolver
// Decode-stage branch resolver between fetch/predecode and rename. Checks the
// fetch prediction of each decode lane in order and raises at most one
// redirect per cycle (PC-relative targets, false predicted-taken, serialized
// instructions and, optionally, returns checked against a return-address
// stack with per-lane checkpoints for backend recovery).
// Build option: RSD_RAS_RETURN_PREDICT_EN - when defined, return checking and
// the RAS (ras_stack) are present; when undefined, returns are plain JALRs
// and the checkpoint outputs are tied to 0.
// Ports:
//   clk, rst, stall, decodeComplete : clock, sync reset, stall, group accepted
//   insnValidIn, class flags, pc, disp, predTaken, predAddr, globalHistory
//                                    : per-lane decode inputs
//   recover, recoverTop, recoverCount : backend RAS restore
//   insnValidOut, insnFlushed, insnFlushTriggering : per-lane flush status
//   brPredTakenOut, brPredAddrOut    : corrected per-lane prediction
//   flushTriggered, recoveredPC, recoveredBrHistory : the redirect
//   ckptTop, ckptCount               : per-lane RAS checkpoint
// -----------------------------------------------------------------------------
module ras_decoded_branch_resolver #(
  parameter int DECODE_WIDTH = 2,
  parameter int RAS_DEPTH    = 8,
  parameter int PC_WIDTH     = 32,
  parameter int GH_WIDTH     = 10,
  parameter int INSN_BYTES   = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           stall,
  input  logic                                           decodeComplete,
  input  logic [DECODE_WIDTH-1:0]                        insnValidIn,
  input  logic [DECODE_WIDTH-1:0]                        isRelBranch,
  input  logic [DECODE_WIDTH-1:0]                        isJal,
  input  logic [DECODE_WIDTH-1:0]                        writePC,
  input  logic [DECODE_WIDTH-1:0]                        isSerialized,
  input  logic [DECODE_WIDTH-1:0]                        isCall,
  input  logic [DECODE_WIDTH-1:0]                        isReturn,
  input  logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0]          pc,
  input  logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0]          disp,
  input  logic [DECODE_WIDTH-1:0]                        predTaken,
  input  logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0]          predAddr,
  input  logic [DECODE_WIDTH-1:0][GH_WIDTH-1:0]          globalHistory,
  input  logic                                           recover,
  input  logic [$clog2(RAS_DEPTH)-1:0]                   recoverTop,
  input  logic [$clog2(RAS_DEPTH):0]                     recoverCount,
  output logic [DECODE_WIDTH-1:0]                        insnValidOut,
  output logic [DECODE_WIDTH-1:0]                        insnFlushed,
  output logic [DECODE_WIDTH-1:0]                        insnFlushTriggering,
  output logic [DECODE_WIDTH-1:0]                        brPredTakenOut,
  output logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0]          brPredAddrOut,
  output logic                                           flushTriggered,
  output logic [PC_WIDTH-1:0]                            recoveredPC,
  output logic [GH_WIDTH-1:0]                            recoveredBrHistory,
  output logic [DECODE_WIDTH-1:0][$clog2(RAS_DEPTH)-1:0] ckptTop,
  output logic [DECODE_WIDTH-1:0][$clog2(RAS_DEPTH):0]   ckptCount
);
  import ras_decoded_branch_resolver_pkg::*;

  localparam int PTR_WIDTH = $clog2(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0] INSN_STEP = PC_WIDTH'(INSN_BYTES);

  logic [DECODE_WIDTH-1:0]               retCheck;     // lane is a return with a non-empty RAS
  logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0] rasTopAddr;
  logic [DECODE_WIDTH-1:0]               applyMask;
  logic [DECODE_WIDTH-1:0]               triggerMask;
  logic [DECODE_WIDTH-1:0]               flushedMask;
  logic                                  flush;
  logic [PC_WIDTH-1:0]                   flushTarget;
  logic [GH_WIDTH-1:0]                   flushHistory;

`ifdef RSD_RAS_RETURN_PREDICT_EN
  logic [DECODE_WIDTH-1:0]               rasPush;
  logic [DECODE_WIDTH-1:0]               rasPop;
  logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0] rasPushAddr;

  // Raw per-lane RAS operations; which of them commit is decided by applyMask.
  always_comb begin
    rasPush     = '0;
    rasPop      = '0;
    rasPushAddr = '0;
    retCheck    = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      rasPush[i]     = insnValidIn[i] & isCall[i];
      rasPop[i]      = insnValidIn[i] & isReturn[i];
      rasPushAddr[i] = pc[i] + INSN_STEP;
      retCheck[i]    = isReturn[i] & (ckptCount[i] != '0);
    end
  end

  ras_stack #(
    .DECODE_WIDTH (DECODE_WIDTH),
    .RAS_DEPTH    (RAS_DEPTH),
    .PC_WIDTH     (PC_WIDTH),
    .PTR_WIDTH    (PTR_WIDTH)
  ) rasStack (
    .clk          (clk),
    .rst          (rst),
    .update       (decodeComplete & ~stall),
    .apply        (applyMask),
    .push         (rasPush),
    .pop          (rasPop),
    .pushAddr     (rasPushAddr),
    .recover      (recover),
    .recoverTop   (recoverTop),
    .recoverCount (recoverCount),
    .ckptTop      (ckptTop),
    .ckptCount    (ckptCount),
    .topAddr      (rasTopAddr)
  );
`else
  logic unusedRasInputs;

  assign unusedRasInputs = ^{clk, rst, stall, decodeComplete, isCall, isReturn,
                             recover, recoverTop, recoverCount, applyMask};
  assign retCheck   = '0;
  assign rasTopAddr = '0;
  assign ckptTop    = '0;
  assign ckptCount  = '0;
`endif

  // Lane scan: stop at the first invalid lane, first flushing lane, or an unchecked JALR.
  always_comb begin
    BranchTargetType     tgtType;
    logic [PC_WIDTH-1:0] laneTgt;
    logic                laneFlush;
    logic                laneStop;
    logic                stop;
    stop         = 1'b0;
    flush        = 1'b0;
    flushTarget  = '0;
    flushHistory = '0;
    applyMask    = '0;
    triggerMask  = '0;
    flushedMask  = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      tgtType   = BTT_NONE;
      laneFlush = 1'b0;
      laneStop  = 1'b0;
      if (!insnValidIn[i]) begin
        laneStop = 1'b1;
      end else if (!writePC[i] && predTaken[i]) begin
        tgtType   = BTT_NEXT_PC;
        laneFlush = 1'b1;
      end else if (isRelBranch[i] && (isJal[i] || predTaken[i])) begin
        tgtType = BTT_PC_REL;
      end else if (retCheck[i]) begin
        tgtType = BTT_RETURN;
      end else if (writePC[i]) begin
        // Register-indirect jump (or return with an empty RAS): cannot be checked here.
        laneStop = 1'b1;
      end else if (isSerialized[i]) begin
        tgtType   = BTT_NEXT_PC;
        laneFlush = 1'b1;
      end else begin
        laneStop = 1'b0;
      end

      case (tgtType)
        BTT_NEXT_PC: laneTgt = pc[i] + INSN_STEP;
        BTT_PC_REL:  laneTgt = pc[i] + disp[i];
        BTT_RETURN:  laneTgt = rasTopAddr[i];
        default:     laneTgt = '0;
      endcase

      if (tgtType == BTT_PC_REL) begin
        laneFlush = (predAddr[i] != laneTgt);
      end else if (tgtType == BTT_RETURN) begin
        laneFlush = (predAddr[i] != laneTgt) || !predTaken[i];
      end else begin
        laneFlush = laneFlush;
      end

      if (!stop) begin
        applyMask[i] = insnValidIn[i];
        if (laneFlush) begin
          flush          = 1'b1;
          triggerMask[i] = 1'b1;
          flushTarget    = laneTgt;
          flushHistory   = globalHistory[i];
          stop           = 1'b1;
        end else if (laneStop) begin
          stop = 1'b1;
        end else begin
          stop = 1'b0;
        end
      end else begin
        flushedMask[i] = flush & insnValidIn[i];
      end
    end
  end

  // Per-lane outputs: the check lane carries the corrected target, younger lanes are squashed.
  always_comb begin
    insnValidOut        = insnValidIn & ~flushedMask;
    insnFlushed         = flushedMask;
    insnFlushTriggering = triggerMask;
    brPredTakenOut      = '0;
    brPredAddrOut       = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      brPredTakenOut[i] = triggerMask[i] ? 1'b1 : predTaken[i];
      brPredAddrOut[i]  = triggerMask[i] ? flushTarget : predAddr[i];
    end
    flushTriggered     = flush;
    recoveredPC        = flushTarget;
    recoveredBrHistory = flushHistory;
  end

endmodule

// File: tb/tb_ras_decoded_branch_resolver.sv
module tb_ras_decoded_branch_resolver;
  localparam int W   = 2;
  localparam int PCW = 32;
  localparam int GHW = 10;
  localparam int PW  = 3;

  logic clk = 1'b0;
  logic rst, stall, decodeComplete;
  logic [W-1:0] insnValidIn, isRelBranch, isJal, writePC, isSerialized, isCall, isReturn, predTaken;
  logic [W-1:0][PCW-1:0] pc, disp, predAddr;
  logic [W-1:0][GHW-1:0] globalHistory;
  logic recover;
  logic [PW-1:0] recoverTop;
  logic [PW:0] recoverCount;
  logic [W-1:0] insnValidOut, insnFlushed, insnFlushTriggering, brPredTakenOut;
  logic [W-1:0][PCW-1:0] brPredAddrOut;
  logic flushTriggered;
  logic [PCW-1:0] recoveredPC;
  logic [GHW-1:0] recoveredBrHistory;
  logic [W-1:0][PW-1:0] ckptTop;
  logic [W-1:0][PW:0] ckptCount;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  ras_decoded_branch_resolver dut (
    .clk(clk), .rst(rst), .stall(stall), .decodeComplete(decodeComplete),
    .insnValidIn(insnValidIn), .isRelBranch(isRelBranch), .isJal(isJal), .writePC(writePC),
    .isSerialized(isSerialized), .isCall(isCall), .isReturn(isReturn), .pc(pc), .disp(disp),
    .predTaken(predTaken), .predAddr(predAddr), .globalHistory(globalHistory),
    .recover(recover), .recoverTop(recoverTop), .recoverCount(recoverCount),
    .insnValidOut(insnValidOut), .insnFlushed(insnFlushed), .insnFlushTriggering(insnFlushTriggering),
    .brPredTakenOut(brPredTakenOut), .brPredAddrOut(brPredAddrOut), .flushTriggered(flushTriggered),
    .recoveredPC(recoveredPC), .recoveredBrHistory(recoveredBrHistory),
    .ckptTop(ckptTop), .ckptCount(ckptCount)
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    stall = 1'b0; decodeComplete = 1'b0; recover = 1'b0;
    recoverTop = '0; recoverCount = '0;
    insnValidIn = '0; isRelBranch = '0; isJal = '0; writePC = '0; isSerialized = '0;
    isCall = '0; isReturn = '0; predTaken = '0;
    pc = '0; disp = '0; predAddr = '0; globalHistory = '0;
  endtask

  // correctly predicted JAL call (disp 0x10)
  task automatic setCall(input int lane, input logic [PCW-1:0] p);
    insnValidIn[lane] = 1'b1; isRelBranch[lane] = 1'b1; isJal[lane] = 1'b1; writePC[lane] = 1'b1;
    isCall[lane] = 1'b1; pc[lane] = p; disp[lane] = 32'h10; predTaken[lane] = 1'b1;
    predAddr[lane] = p + 32'h10;
  endtask

  task automatic setReturn(input int lane, input logic [PCW-1:0] p, input logic [PCW-1:0] pa);
    insnValidIn[lane] = 1'b1; writePC[lane] = 1'b1; isReturn[lane] = 1'b1;
    pc[lane] = p; predTaken[lane] = 1'b1; predAddr[lane] = pa;
  endtask

  task automatic doReset();
    clearInputs(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #2;
    testsRun++; if (flushTriggered !== 1'b0) begin testsFailed++; $display("FAIL reset_flush: got %0h want 0", flushTriggered); end
    testsRun++; if (ckptTop[0] !== 3'd0) begin testsFailed++; $display("FAIL reset_top: got %0d want 0", ckptTop[0]); end
    testsRun++; if (ckptCount[0] !== 4'd0) begin testsFailed++; $display("FAIL reset_count: got %0d want 0", ckptCount[0]); end
    tick();
  endtask

  task automatic test_jal();
    clearInputs();
    insnValidIn = 2'b11; isRelBranch[0] = 1'b1; isJal[0] = 1'b1; writePC[0] = 1'b1;
    pc[0] = 32'h1000; disp[0] = 32'h40; predAddr[0] = 32'h1004; globalHistory[0] = 10'h2A5;
    pc[1] = 32'h1004;
    #2;
    testsRun++; if (flushTriggered !== 1'b1) begin testsFailed++; $display("FAIL jal_flush: got %0h want 1", flushTriggered); end
    testsRun++; if (recoveredPC !== 32'h1040) begin testsFailed++; $display("FAIL jal_pc: got %0h want 1040", recoveredPC); end
    testsRun++; if (recoveredBrHistory !== 10'h2A5) begin testsFailed++; $display("FAIL jal_hist: got %0h want 2a5", recoveredBrHistory); end
    testsRun++; if (insnFlushed !== 2'b10) begin testsFailed++; $display("FAIL jal_flushed: got %b want 10", insnFlushed); end
    testsRun++; if (insnValidOut !== 2'b01) begin testsFailed++; $display("FAIL jal_valid: got %b want 01", insnValidOut); end
    testsRun++; if (insnFlushTriggering !== 2'b01) begin testsFailed++; $display("FAIL jal_trig: got %b want 01", insnFlushTriggering); end
    testsRun++; if (brPredTakenOut[0] !== 1'b1) begin testsFailed++; $display("FAIL jal_taken: got %0h want 1", brPredTakenOut[0]); end
    testsRun++; if (brPredAddrOut[0] !== 32'h1040) begin testsFailed++; $display("FAIL jal_addr: got %0h want 1040", brPredAddrOut[0]); end
    tick();
  endtask

  task automatic test_serialized();
    clearInputs();
    insnValidIn = 2'b11; pc[0] = 32'h600; pc[1] = 32'h604; isSerialized[1] = 1'b1;
    predAddr[1] = 32'h777;
    #2;
    testsRun++; if (recoveredPC !== 32'h608) begin testsFailed++; $display("FAIL ser_pc: got %0h want 608", recoveredPC); end
    testsRun++; if (insnFlushTriggering !== 2'b10) begin testsFailed++; $display("FAIL ser_trig: got %b want 10", insnFlushTriggering); end
    testsRun++; if (insnValidOut !== 2'b11) begin testsFailed++; $display("FAIL ser_valid: got %b want 11", insnValidOut); end
    testsRun++; if (brPredAddrOut[0] !== 32'h0) begin testsFailed++; $display("FAIL ser_pass: got %0h want 0", brPredAddrOut[0]); end
    tick();
  endtask

  task automatic test_stall();
    doReset();
    setCall(0, 32'h480); disp[0] = 32'h80; predAddr[0] = 32'h500;
    insnValidIn[1] = 1'b1; pc[1] = 32'h500; predTaken[1] = 1'b1; predAddr[1] = 32'h900;
    stall = 1'b1; decodeComplete = 1'b1;
    #2;
    testsRun++; if (flushTriggered !== 1'b1) begin testsFailed++; $display("FAIL stall_flush: got %0h want 1", flushTriggered); end
    testsRun++; if (recoveredPC !== 32'h504) begin testsFailed++; $display("FAIL stall_pc: got %0h want 504", recoveredPC); end
    testsRun++; if (insnFlushTriggering !== 2'b10) begin testsFailed++; $display("FAIL stall_trig: got %b want 10", insnFlushTriggering); end
    tick();
    clearInputs();
    #2;
    testsRun++; if (ckptCount[0] !== 4'd0) begin testsFailed++; $display("FAIL stall_noupd: got %0d want 0", ckptCount[0]); end
    tick();
  endtask

  task automatic test_call_return();
    doReset();
    setCall(0, 32'h2000); decodeComplete = 1'b1;
    #2;
    testsRun++; if (flushTriggered !== 1'b0) begin testsFailed++; $display("FAIL call_noflush: got %0h want 0", flushTriggered); end
    tick();
    clearInputs(); setReturn(0, 32'h2010, 32'h3000); decodeComplete = 1'b1;
    #2;
`ifdef RSD_RAS_RETURN_PREDICT_EN
    testsRun++; if (flushTriggered !== 1'b1) begin testsFailed++; $display("FAIL ret_flush: got %0h want 1", flushTriggered); end
    testsRun++; if (recoveredPC !== 32'h2004) begin testsFailed++; $display("FAIL ret_pc: got %0h want 2004", recoveredPC); end
    testsRun++; if (ckptCount[0] !== 4'd1) begin testsFailed++; $display("FAIL ret_cnt_before: got %0d want 1", ckptCount[0]); end
    tick();
    clearInputs();
    #2;
    testsRun++; if (ckptCount[0] !== 4'd0) begin testsFailed++; $display("FAIL ret_cnt_after: got %0d want 0", ckptCount[0]); end
`else
    testsRun++; if (flushTriggered !== 1'b0) begin testsFailed++; $display("FAIL jalr_noflush: got %0h want 0", flushTriggered); end
    testsRun++; if (brPredAddrOut[0] !== 32'h3000) begin testsFailed++; $display("FAIL jalr_pass: got %0h want 3000", brPredAddrOut[0]); end
`endif
    tick();
  endtask

`ifdef RSD_RAS_RETURN_PREDICT_EN
  task automatic test_overflow();
    doReset();
    for (int k = 1; k <= 9; k++) begin
      clearInputs(); setCall(0, 32'h100 * k); decodeComplete = 1'b1; tick();
    end
    clearInputs();
    #2;
    testsRun++; if (ckptCount[0] !== 4'd8) begin testsFailed++; $display("FAIL ovf_count: got %0d want 8", ckptCount[0]); end
    testsRun++; if (ckptTop[0] !== 3'd1) begin testsFailed++; $display("FAIL ovf_top: got %0d want 1", ckptTop[0]); end
    for (int k = 9; k >= 2; k--) begin
      clearInputs(); setReturn(0, 32'h5000, 32'h0); decodeComplete = 1'b1;
      #2;
      testsRun++;
      if (recoveredPC !== 32'h100 * k + 32'h4) begin
        testsFailed++; $display("FAIL ovf_ret%0d: got %0h want %0h", k, recoveredPC, 32'h100 * k + 32'h4);
      end
      tick();
    end
    clearInputs(); setReturn(0, 32'h5000, 32'h0); decodeComplete = 1'b1;
    #2;
    testsRun++; if (flushTriggered !== 1'b0) begin testsFailed++; $display("FAIL unf_noflush: got %0h want 0", flushTriggered); end
    testsRun++; if (ckptCount[0] !== 4'd0) begin testsFailed++; $display("FAIL unf_count: got %0d want 0", ckptCount[0]); end
    tick();
  endtask

  task automatic test_same_cycle();
    doReset();
    setCall(0, 32'h4000); setReturn(1, 32'h4010, 32'h4004); decodeComplete = 1'b1;
    #2;
    testsRun++; if (flushTriggered !== 1'b0) begin testsFailed++; $display("FAIL pair_noflush: got %0h want 0", flushTriggered); end
    testsRun++; if (ckptCount[1] !== 4'd1) begin testsFailed++; $display("FAIL pair_ckcnt: got %0d want 1", ckptCount[1]); end
    testsRun++; if (ckptTop[1] !== 3'd1) begin testsFailed++; $display("FAIL pair_cktop: got %0d want 1", ckptTop[1]); end
    tick();
    clearInputs();
    #2;
    testsRun++; if (ckptCount[0] !== 4'd0) begin testsFailed++; $display("FAIL pair_cnt: got %0d want 0", ckptCount[0]); end
    tick();
  endtask

  task automatic test_recover();
    doReset();
    for (int k = 0; k < 3; k++) begin
      clearInputs(); setCall(0, 32'h7000 + 32'h100 * k); decodeComplete = 1'b1; tick();
    end
    clearInputs();
    #2;
    testsRun++; if (ckptTop[0] !== 3'd3) begin testsFailed++; $display("FAIL snap_top: got %0d want 3", ckptTop[0]); end
    for (int k = 3; k < 5; k++) begin
      clearInputs(); setCall(0, 32'h7000 + 32'h100 * k); decodeComplete = 1'b1; tick();
    end
    clearInputs(); setCall(0, 32'h7500); decodeComplete = 1'b1;
    recover = 1'b1; recoverTop = 3'd3; recoverCount = 4'd3;
    tick();
    clearInputs(); setReturn(0, 32'h8000, 32'h0); decodeComplete = 1'b1;
    #2;
    testsRun++; if (ckptCount[0] !== 4'd3) begin testsFailed++; $display("FAIL rec_count: got %0d want 3", ckptCount[0]); end
    testsRun++; if (ckptTop[0] !== 3'd3) begin testsFailed++; $display("FAIL rec_top: got %0d want 3", ckptTop[0]); end
    testsRun++; if (recoveredPC !== 32'h7204) begin testsFailed++; $display("FAIL rec_entry: got %0h want 7204", recoveredPC); end
    tick();
    // reset beats both recover and a decode push
    clearInputs(); setCall(0, 32'h9000); decodeComplete = 1'b1;
    recover = 1'b1; recoverTop = 3'd5; recoverCount = 4'd5; rst = 1'b1;
    tick();
    rst = 1'b0; clearInputs();
    #2;
    testsRun++; if (ckptCount[0] !== 4'd0) begin testsFailed++; $display("FAIL rst_mid_count: got %0d want 0", ckptCount[0]); end
    testsRun++; if (ckptTop[0] !== 3'd0) begin testsFailed++; $display("FAIL rst_mid_top: got %0d want 0", ckptTop[0]); end
    tick();
  endtask
`endif

  initial begin
    clearInputs();
    rst = 1'b1;
    test_reset();
    test_jal();
    test_serialized();
    test_stall();
    test_call_return();
`ifdef RSD_RAS_RETURN_PREDICT_EN
    test_overflow();
    test_same_cycle();
    test_recover();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ras_decoded_branch_resolver.md
Name: ras_decoded_branch_resolver

Overview:
- Decode-stage branch resolver, parametrised in lane count, generalising the existing decode-stage resolver.
- Adds a sequential circular return-address stack (RAS) with per-lane checkpoints and backend recovery.
- Sits between fetch/predecode and rename.
- Corrects PC-relative targets, not-branch-predicted-taken, serialized instructions and mispredicted returns; emits one redirect per cycle.

Parameters:
- DECODE_WIDTH, 2, number of decode lanes.
- RAS_DEPTH, 8, RAS entries; power of two, >=2.
- PC_WIDTH, 32, PC bits.
- GH_WIDTH, 10, global-history bits.
- INSN_BYTES, 4, PC increment per instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  decode stalled; no state update.
- decodeComplete  in  1  decode group accepted this cycle.
- insnValidIn  in  [W]x1  lane valid.
- isRelBranch / isJal / writePC / isSerialized  in  [W]x1 each  decoded class flags.
- isCall / isReturn  in  [W]x1 each  call (rd=x1/x5), return (JALR rs1=x1/x5, rd!=link).
- pc  in  [W]xPC_WIDTH  lane PC.
- disp  in  [W]xPC_WIDTH  sign-extended branch/JAL displacement.
- predTaken  in  [W]x1  fetch prediction: taken.
- predAddr  in  [W]xPC_WIDTH  fetch prediction: target.
- globalHistory  in  [W]xGH_WIDTH  fetch prediction: global history.
- recover  in  1  backend flush restore.
- recoverTop  in  log2(RAS_DEPTH)  restore pointer.
- recoverCount  in  log2(RAS_DEPTH)+1  restore occupancy.
- insnValidOut / insnFlushed / insnFlushTriggering  out  [W]x1.
- brPredTakenOut  out  [W]x1  corrected prediction: taken.
- brPredAddrOut  out  [W]xPC_WIDTH  corrected prediction: target.
- flushTriggered  out  1.
- recoveredPC  out  PC_WIDTH.
- recoveredBrHistory  out  GH_WIDTH.
- ckptTop  out  [W]xlog2(RAS_DEPTH)  RAS top before each lane's operation; stored with the instruction for backend recovery.
- ckptCount  out  [W]x(log2(RAS_DEPTH)+1)  RAS occupancy before each lane's operation.

Behaviour:
- Reset: top=0, count=0, all RAS entries 0. Combinational outputs are driven from current inputs and state; flushTriggered=0 whenever all insnValidIn=0.
- Latency: resolution is combinational, same cycle. RAS updates on the next clk edge when decodeComplete && !stall && !recover.
- Lane scan runs lowest to highest and stops at the first invalid lane or first redirecting lane (the check lane). Redirect conditions, in priority order:
  - not writePC && predTaken → forced flush, target pc+INSN_BYTES;
  - isRelBranch && (isJal || predTaken) → target pc+disp; flush if predAddr differs;
  - isReturn && count>0 → target RAS[top]; flush if predAddr differs or !predTaken;
  - isReturn && count==0, or other JALR → no check, scan stops;
  - isSerialized → forced flush, target pc+INSN_BYTES.
- On flush:
  - lanes above the check lane: insnValidOut=0, insnFlushed=1;
  - check lane: insnFlushTriggering=1, brPredTakenOut=1, brPredAddrOut=target;
  - recoveredPC=target, recoveredBrHistory=globalHistory of the check lane.
  - Without a flush, the corrected-prediction outputs pass predTaken/predAddr through.
- RAS lane processing: only lanes at or below the check lane, and valid, apply their operations, sequentially in lane order within a cycle.
  - Call: top=top+1 mod RAS_DEPTH; write pc+INSN_BYTES; count=min(count+1, RAS_DEPTH). Overflow overwrites the oldest entry.
  - Return: if count>0, top=top-1 mod RAS_DEPTH and count-1. At count 0, no change (underflow is ignored).
  - Call && isReturn on the same instruction (coroutine): pop, then push.
- ckptTop/ckptCount for lane i equal the state after lanes 0..i-1 have applied.
- recover has priority: top←recoverTop, count←recoverCount, entries untouched; decode-side updates that cycle are discarded.
- stall=1: no update; outputs remain combinationally valid.
- Reset asserted mid-operation wins over recover and decode updates.

Optional Feature:
- RSD_RAS_RETURN_PREDICT_EN.
- Defined: return checking as above.
- Undefined: the RAS and checkpoint logic is removed; ckpt outputs tie to 0; isReturn is treated as a plain JALR (no check). The block then reduces to a width-generic version of the existing resolver.

Decomposition:
- Shared package (FetchUnitTypes): RasPtrPath, RasCountPath, RasCheckpoint struct {top, count}, RAS_DEPTH constant, BranchTargetType enum extended with BTT_RETURN.
- One sub-module: ras_stack. It holds the entry array, top and count; provides combinational per-lane checkpoint and top-of-stack forwarding; applies a per-lane push/pop vector plus recover.

Test Plan:
- JAL at lane0, pc=0x1000, disp=0x40, predAddr=0x1004 → flushTriggered=1, recoveredPC=0x1040, lane1 insnFlushed=1.
- Call at pc=0x2000, then a return next cycle with predAddr=0x3000 → flush, recoveredPC=0x2004, count goes 1→0.
- RAS_DEPTH=8: 9 calls at pc=0x100*k, then 8 returns → targets are pcs of calls 9..2, plus 4 each; a 9th return is unchecked with count=0.
- Call in lane0 and return in lane1 in one cycle, predAddr=lane0 pc+4 → no flush; ckptCount lane1=1; count stays at its pre-cycle value.
- Snapshot (top=3,count=3), 2 further calls, then recover with (3,3) simultaneous with a decode call → state is (3,3); next return yields entry 3.
- Non-branch with predTaken=1 at pc=0x500, stall=1 → flush with recoveredPC=0x504; no RAS change.
